// File: rtl/fetch_if.sv
// Handshake and ROM-side bundle between the core control/datapath and the fetch sequencer.
// The sequencer takes the slave modport and the driving environment takes the master modport.
interface fetch_if;
  logic        start_i;
  logic [1:0]  prog_sel_i;
  logic [7:0]  instr_i;
  logic        stall_i;
  logic        branch_taken_i;
  logic        branch_back_i;
  logic [7:0]  branch_off_i;
  logic [7:0]  pc_o;
  logic        instr_valid_o;
  logic        busy_o;
  logic        done_o;
  logic        fault_o;
  logic [15:0] retired_o;

  modport master (
    output start_i, prog_sel_i, instr_i, stall_i, branch_taken_i, branch_back_i, branch_off_i,
    input  pc_o, instr_valid_o, busy_o, done_o, fault_o, retired_o
  );

  modport slave (
    input  start_i, prog_sel_i, instr_i, stall_i, branch_taken_i, branch_back_i, branch_off_i,
    output pc_o, instr_valid_o, busy_o, done_o, fault_o, retired_o
  );
endinterface

// File: rtl/fetch_sequencer.sv
// PC owner for the 8-bit core. It launches one of three resident programs and applies relative branches.
// It also detects halt and out-of-range PCs, and counts retired instructions with saturation.
module fetch_sequencer #(
  parameter logic [7:0] PROG0_BASE  = 8'd0,
  parameter logic [7:0] PROG1_BASE  = 8'd98,
  parameter logic [7:0] PROG2_BASE  = 8'd150,
  parameter logic [7:0] ROM_LAST    = 8'd219,
  parameter logic [7:0] HALT_OPCODE = 8'b10001000
) (
  input logic    clk_i,
  input logic    reset_i,
  fetch_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE, FAULT} state_t;

  state_t            state;
  logic [7:0]        pc;
  logic [15:0]       retired;
  logic              done;
  logic              fault;
  logic signed [9:0] target;
  logic              target_bad;
  logic              halt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Two guard bits cover both the carry out of pc+1+off and the borrow of pc-off.
  always_comb begin
    target = signed'({2'b00, pc}) + 10'sd1;
    if (bus.branch_taken_i && !bus.branch_back_i)
      target = signed'({2'b00, pc}) + 10'sd1 + signed'({2'b00, bus.branch_off_i});
    else if (bus.branch_taken_i && bus.branch_back_i)
      target = signed'({2'b00, pc}) - signed'({2'b00, bus.branch_off_i});
    target_bad = target[9] || (target[8:0] > {1'b0, ROM_LAST});
    halt       = (bus.instr_i == HALT_OPCODE);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state   <= IDLE;
      pc      <= 8'd0;
      retired <= 16'd0;
      done    <= 1'b0;
      fault   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (!bus.stall_i) begin
            retired <= sat_inc(retired);
            if (halt) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (target_bad) begin
              state <= FAULT;
              fault <= 1'b1;
            end else begin
              pc <= target[7:0];
            end
          end
        end
        default: begin
          if (bus.start_i) begin
            if (bus.prog_sel_i == 2'd3) begin
              state <= FAULT;
              fault <= 1'b1;
              done  <= 1'b0;
            end else begin
              state   <= RUN;
              retired <= 16'd0;
              done    <= 1'b0;
              fault   <= 1'b0;
              case (bus.prog_sel_i)
                2'd0:    pc <= PROG0_BASE;
                2'd1:    pc <= PROG1_BASE;
                default: pc <= PROG2_BASE;
              endcase
            end
          end
        end
      endcase
    end
  end

  assign bus.pc_o          = pc;
  assign bus.busy_o        = (state == RUN);
  assign bus.instr_valid_o = (state == RUN) && !bus.stall_i;
  assign bus.done_o        = done;
  assign bus.fault_o       = fault;
  assign bus.retired_o     = retired;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: start/select, branches, stall, halt, faults, saturation, reset.
module tb_fetch_sequencer;

  logic clk_i;
  logic reset_i;
  int   total;
  int   bad;

  fetch_if bus ();

  fetch_sequencer dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .bus    (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start_i        = 1'b0;
    bus.prog_sel_i     = 2'd0;
    bus.instr_i        = 8'h00;
    bus.stall_i        = 1'b0;
    bus.branch_taken_i = 1'b0;
    bus.branch_back_i  = 1'b0;
    bus.branch_off_i   = 8'd0;
  endtask

  task automatic start(input logic [1:0] sel);
    bus.start_i    = 1'b1;
    bus.prog_sel_i = sel;
    tick();
    bus.start_i    = 1'b0;
  endtask

  // One executed cycle with an optional branch; back selects branchb.
  task automatic br(input logic taken, input logic back, input logic [7:0] off);
    bus.branch_taken_i = taken;
    bus.branch_back_i  = back;
    bus.branch_off_i   = off;
    tick();
    bus.branch_taken_i = 1'b0;
    bus.branch_back_i  = 1'b0;
    bus.branch_off_i   = 8'd0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle_inputs();
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
    chk("rst_pc", bus.pc_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_done", bus.done_o, 0);
    chk("rst_fault", bus.fault_o, 0);
    chk("rst_ret", bus.retired_o, 0);
    chk("rst_ivld", bus.instr_valid_o, 0);

    start(2'd1);
    chk("st1_pc", bus.pc_o, 98);
    chk("st1_busy", bus.busy_o, 1);
    chk("st1_ivld", bus.instr_valid_o, 1);
    chk("st1_ret", bus.retired_o, 0);

    br(1, 0, 8'd28);
    chk("fwd_to127", bus.pc_o, 127);
    br(1, 0, 8'd10);
    chk("fwd_138", bus.pc_o, 138);
    br(1, 0, 8'd9);
    chk("fwd_148", bus.pc_o, 148);
    br(1, 1, 8'd35);
    chk("back_113", bus.pc_o, 113);
    br(1, 1, 8'd96);
    chk("back_17", bus.pc_o, 17);
    chk("ret_5", bus.retired_o, 5);

    bus.stall_i = 1'b1;
    bus.branch_taken_i = 1'b1;
    bus.branch_off_i = 8'd8;
    #1;
    chk("stall_ivld", bus.instr_valid_o, 0);
    chk("stall_busy", bus.busy_o, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", bus.pc_o, 17);
      chk("stall_ret", bus.retired_o, 5);
    end
    bus.stall_i = 1'b0;
    br(1, 0, 8'd8);
    chk("post_stall_pc", bus.pc_o, 26);
    chk("post_stall_ret", bus.retired_o, 6);

    bus.start_i = 1'b1;
    bus.prog_sel_i = 2'd2;
    br(1, 0, 8'd70);
    bus.start_i = 1'b0;
    chk("start_in_run_ign", bus.pc_o, 97);
    chk("ret_7", bus.retired_o, 7);

    bus.instr_i = 8'h88;
    br(1, 0, 8'd5);
    bus.instr_i = 8'h00;
    chk("halt_pc", bus.pc_o, 97);
    chk("halt_done", bus.done_o, 1);
    chk("halt_busy", bus.busy_o, 0);
    chk("halt_ret", bus.retired_o, 8);
    tick();
    chk("done_level", bus.done_o, 1);

    start(2'd2);
    chk("st2_pc", bus.pc_o, 150);
    chk("st2_done", bus.done_o, 0);
    chk("st2_ret", bus.retired_o, 0);
    br(1, 1, 8'd146);
    chk("back_4", bus.pc_o, 4);
    br(0, 0, 8'd0);
    chk("seq_5", bus.pc_o, 5);
    br(1, 1, 8'd9);
    chk("neg_fault", bus.fault_o, 1);
    chk("neg_pc", bus.pc_o, 5);
    chk("neg_busy", bus.busy_o, 0);
    chk("neg_ret", bus.retired_o, 3);

    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    chk("rst2_fault", bus.fault_o, 0);
    start(2'd3);
    chk("sel3_fault", bus.fault_o, 1);
    chk("sel3_pc", bus.pc_o, 0);
    chk("sel3_busy", bus.busy_o, 0);

    start(2'd2);
    chk("st2b_fault", bus.fault_o, 0);
    br(1, 0, 8'd67);
    chk("fwd_218", bus.pc_o, 218);
    br(0, 0, 8'd0);
    chk("seq_219", bus.pc_o, 219);
    br(0, 0, 8'd0);
    chk("range_fault", bus.fault_o, 1);
    chk("range_pc", bus.pc_o, 219);

    start(2'd0);
    chk("st0_pc", bus.pc_o, 0);
    br(1, 0, 8'd255);
    chk("carry_fault", bus.fault_o, 1);
    chk("carry_pc", bus.pc_o, 0);

    start(2'd0);
    bus.branch_taken_i = 1'b1;
    bus.branch_back_i  = 1'b1;
    bus.branch_off_i   = 8'd0;
    for (int i = 0; i < 65534; i++) tick();
    chk("sat_fffe", bus.retired_o, 16'hFFFE);
    for (int i = 0; i < 3; i++) tick();
    chk("sat_ffff", bus.retired_o, 16'hFFFF);
    chk("sat_pc", bus.pc_o, 0);
    chk("sat_busy", bus.busy_o, 1);

    br(1, 0, 8'd40);
    chk("pre_rst_pc", bus.pc_o, 41);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    chk("midrun_rst_pc", bus.pc_o, 0);
    chk("midrun_rst_busy", bus.busy_o, 0);
    chk("midrun_rst_ret", bus.retired_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
